sha256_msg_feeder: RTL

SHA256_MSG_FEEDER -- requirements
Module: sha256_msg_feeder

---
 rtl/sha256_pkg.sv | 24 ++
 rtl/hdr_store.sv | 28 ++
 rtl/sha256_msg_feeder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the double-SHA-256 message feeder: FSM states,
// block codes and the fixed padding/length words.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FEED     = 3'd1,
    ST_ROUNDS   = 3'd2,
    ST_WAIT_DIG = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [1:0] BLK_HDR  = 2'd0;
  localparam logic [1:0] BLK_TAIL = 2'd1;
  localparam logic [1:0] BLK_DIG  = 2'd2;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam logic [31:0] LEN_HDR  = 32'h0000_0280;
  localparam logic [31:0] LEN_DIG  = 32'h0000_0100;

  localparam logic [6:0] FEED_LAST  = 7'd15;
  localparam logic [6:0] ROUND_LAST = 7'd63;

endpackage

// File: rtl/hdr_store.sv
// Header word register file: one synchronous write port, one combinational
// read port. Out-of-range writes are dropped and out-of-range reads return 0.
module hdr_store #(
  parameter int DEPTH = 19
) (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata
);

  localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset on purpose; header contents must survive a
  // stream abort, and a reset-free array maps onto plain registers/LUT RAM.
  always_ff @(posedge clk) begin
    if (we && (waddr <= LAST_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr <= LAST_IDX) ? mem[raddr] : '0;

endmodule

// File: rtl/sha256_msg_feeder.sv
// Message-word sequencer for a double SHA-256: header block, header tail
// with nonce and padding, then the first-pass digest block. Outputs are registered.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int HDR_WORDS = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hdr_wr,
  input  logic [4:0]   hdr_addr,
  input  logic [31:0]  hdr_data,
  input  logic [31:0]  nonce,
  input  logic         start,
  input  logic [255:0] digest_in,
  input  logic         digest_valid,
  output logic [31:0]  word_out,
  output logic         word_valid,
  output logic [1:0]   block,
  output logic [6:0]   select,
  output logic         busy,
  output logic         done
);

  state_t       state, nxt_state;
  logic [1:0]   nxt_block;
  logic [6:0]   nxt_select;
  logic         nxt_valid, nxt_busy, nxt_done;
  logic [31:0]  nxt_word;

  logic [31:0]  nonce_q;
  logic [255:0] digest_q;
  logic [255:0] dig_src;
  logic [31:0]  dig_word;
  logic [4:0]   hdr_raddr;
  logic [31:0]  hdr_rdata;

  hdr_store #(.DEPTH(HDR_WORDS)) u_hdr_store (
    .clk   (clk),
    .we    (hdr_wr && (state == ST_IDLE)),
    .waddr (hdr_addr),
    .wdata (hdr_data),
    .raddr (hdr_raddr),
    .rdata (hdr_rdata)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    nxt_state  = state;
    nxt_block  = block;
    nxt_select = select;
    nxt_valid  = 1'b0;
    nxt_busy   = 1'b0;
    nxt_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        nxt_block  = BLK_HDR;
        nxt_select = '0;
        if (start) begin
          nxt_state = ST_FEED;
          nxt_valid = 1'b1;
          nxt_busy  = 1'b1;
        end
      end
      ST_FEED: begin
        nxt_busy   = 1'b1;
        nxt_select = select + 7'd1;
        if (select == FEED_LAST) nxt_state = ST_ROUNDS;
        else                     nxt_valid = 1'b1;
      end
      ST_ROUNDS: begin
        nxt_busy   = 1'b1;
        nxt_select = select + 7'd1;
        if (select == ROUND_LAST) begin
          nxt_select = '0;
          case (block)
            BLK_HDR: begin
              nxt_state = ST_FEED;
              nxt_block = BLK_TAIL;
              nxt_valid = 1'b1;
            end
            BLK_TAIL: nxt_state = ST_WAIT_DIG;
            default: begin
              nxt_state = ST_DONE;
              nxt_busy  = 1'b0;
              nxt_done  = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT_DIG: begin
        nxt_busy   = 1'b1;
        nxt_select = '0;
        if (digest_valid) begin
          nxt_state = ST_FEED;
          nxt_block = BLK_DIG;
          nxt_valid = 1'b1;
        end
      end
      ST_DONE: begin
        nxt_state  = ST_IDLE;
        nxt_block  = BLK_HDR;
        nxt_select = '0;
      end
      default: begin
        nxt_state  = ST_IDLE;
        nxt_block  = BLK_HDR;
        nxt_select = '0;
      end
    endcase
  end

  // The word is chosen from the upcoming block/select so it lands in the
  // output register alongside them; the first digest word bypasses digest_q.
  assign hdr_raddr = (nxt_block == BLK_TAIL) ? 5'd16 + {1'b0, nxt_select[3:0]}
                                             : {1'b0, nxt_select[3:0]};
  assign dig_src   = (state == ST_WAIT_DIG) ? digest_in : digest_q;
  assign dig_word  = dig_src[{~nxt_select[2:0], 5'b0} +: 32];

  always_comb begin
    nxt_word = '0;
    case (nxt_block)
      BLK_HDR: nxt_word = hdr_rdata;
      BLK_TAIL: begin
        case (nxt_select)
          7'd0, 7'd1, 7'd2: nxt_word = hdr_rdata;
          7'd3:             nxt_word = nonce_q;
          7'd4:             nxt_word = PAD_WORD;
          7'd15:            nxt_word = LEN_HDR;
          default:          nxt_word = '0;
        endcase
      end
      BLK_DIG: begin
        if (nxt_select < 7'd8)        nxt_word = dig_word;
        else if (nxt_select == 7'd8)  nxt_word = PAD_WORD;
        else if (nxt_select == 7'd15) nxt_word = LEN_DIG;
        else                          nxt_word = '0;
      end
      default: nxt_word = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      block      <= BLK_HDR;
      select     <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt_state;
      block      <= nxt_block;
      select     <= nxt_select;
      word_out   <= nxt_valid ? nxt_word : '0;
      word_valid <= nxt_valid;
      busy       <= nxt_busy;
      done       <= nxt_done;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && start)            nonce_q  <= nonce;
    if ((state == ST_WAIT_DIG) && digest_valid) digest_q <= digest_in;
  end

endmodule
